// File: rtl/mvm_stream_ctrl_pkg.sv
// Shared types and widths for the stream-attached matrix-vector multiply controller.
package mvm_pkg;

  localparam int unsigned MAT_SCALE    = 3;
  localparam int unsigned INPUT_WIDTH  = 8;
  localparam int unsigned OUTPUT_WIDTH = 16;
  localparam int unsigned VEC_ADDR_W   = $clog2(MAT_SCALE);
  localparam int unsigned MAT_ADDR_W   = $clog2(MAT_SCALE * MAT_SCALE);

  typedef logic signed [INPUT_WIDTH-1:0]  elem_t;
  typedef logic signed [OUTPUT_WIDTH-1:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_X,
    COMPUTE,
    DRAIN,
    OUT_ADDR,
    OUT_VALID
  } state_t;

endpackage

// File: rtl/mvm_stream_ctrl_if.sv
// Stream handshakes plus datapath control (memory enables/addresses, accumulator clear, done).
interface mvm_stream_ctrl_if
  import mvm_pkg::*;
#(
  parameter int unsigned VEC_W = VEC_ADDR_W,
  parameter int unsigned MAT_W = MAT_ADDR_W
) ();

  logic             s_valid;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready;
  logic             wr_en_a;
  logic [MAT_W-1:0] addr_a;
  logic             wr_en_x;
  logic [VEC_W-1:0] addr_x;
  logic             wr_en_y;
  logic [VEC_W-1:0] addr_y;
  logic             clear_acc;
  logic             done;

  modport master (
    input  s_valid, m_ready,
    output s_ready, m_valid, wr_en_a, addr_a, wr_en_x, addr_x,
           wr_en_y, addr_y, clear_acc, done
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, m_valid, wr_en_a, addr_a, wr_en_x, addr_x,
           wr_en_y, addr_y, clear_acc, done
  );

endinterface

// File: rtl/mvm_stream_ctrl_wrap_counter.sv
// Address counter that wraps from TOP back to zero; last flags the terminal count.
module wrap_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned TOP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             last
);

  logic [WIDTH-1:0] out_q, out_d;

  assign last = (out_q == WIDTH'(TOP));
  assign out  = out_q;

  always_comb begin
    out_d = out_q;
    if (clr) begin
      out_d = '0;
    end else if (en) begin
      out_d = last ? '0 : out_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/mvm_stream_ctrl.sv
// Sequences load of A and x from a stream, a one-product-per-cycle MAC schedule,
// and a backpressured drain of y, then pulses done.
module mvm_stream_ctrl #(
  parameter int unsigned MAT_SCALE = mvm_pkg::MAT_SCALE
) (
  input  logic              clk,
  input  logic              reset,
  mvm_stream_ctrl_if.master bus
);

  import mvm_pkg::*;

  localparam int unsigned VEC_W   = $clog2(MAT_SCALE);
  localparam int unsigned MAT_W   = $clog2(MAT_SCALE * MAT_SCALE);
  localparam int unsigned MAT_TOP = MAT_SCALE * MAT_SCALE - 1;
  localparam int unsigned VEC_TOP = MAT_SCALE - 1;

  state_t state_q, state_d;
  logic   s_ready_q, s_ready_d;
  logic   m_valid_q, m_valid_d;
  logic   done_q, done_d;
  logic   clear_acc_q, clear_acc_d;
  logic   wr_en_y_q, wr_en_y_d;

  logic             a_en, x_en, y_en, cnt_clr;
  logic             a_last, x_last, y_last;
  logic [MAT_W-1:0] addr_a;
  logic [VEC_W-1:0] addr_x;
  logic [VEC_W-1:0] addr_y;
  logic             s_hs, m_hs;

  assign s_hs = s_ready_q && bus.s_valid;
  assign m_hs = m_valid_q && bus.m_ready;

  // addr_y doubles as the delayed row index: it steps on each row write, so it
  // is back at zero once the final row lands in DRAIN.
  wrap_counter #(.WIDTH(MAT_W), .TOP(MAT_TOP)) u_cnt_a (
    .clk(clk), .reset(reset), .en(a_en), .clr(cnt_clr), .out(addr_a), .last(a_last)
  );
  wrap_counter #(.WIDTH(VEC_W), .TOP(VEC_TOP)) u_cnt_x (
    .clk(clk), .reset(reset), .en(x_en), .clr(cnt_clr), .out(addr_x), .last(x_last)
  );
  wrap_counter #(.WIDTH(VEC_W), .TOP(VEC_TOP)) u_cnt_y (
    .clk(clk), .reset(reset), .en(y_en), .clr(cnt_clr), .out(addr_y), .last(y_last)
  );

  // Next state; the MAC tag (clear/write) is registered so it aligns with the product.
  always_comb begin
    state_d     = state_q;
    s_ready_d   = 1'b0;
    m_valid_d   = 1'b0;
    done_d      = 1'b0;
    clear_acc_d = 1'b1;
    wr_en_y_d   = 1'b0;
    a_en        = 1'b0;
    x_en        = 1'b0;
    y_en        = wr_en_y_q;
    cnt_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d   = LOAD_A;
        s_ready_d = 1'b1;
        cnt_clr   = 1'b1;
      end
      LOAD_A: begin
        s_ready_d = 1'b1;
        a_en      = s_hs;
        if (s_hs && a_last) state_d = LOAD_X;
      end
      LOAD_X: begin
        x_en = s_hs;
        if (s_hs && x_last) state_d = COMPUTE;
        else                s_ready_d = 1'b1;
      end
      COMPUTE: begin
        a_en        = 1'b1;
        x_en        = 1'b1;
        clear_acc_d = x_last;
        wr_en_y_d   = x_last;
        if (a_last) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = OUT_ADDR;
      end
      OUT_ADDR: begin
        state_d   = OUT_VALID;
        m_valid_d = 1'b1;
      end
      OUT_VALID: begin
        m_valid_d = !m_hs;
        y_en      = m_hs;
        if (m_hs) begin
          if (y_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = OUT_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      clear_acc_q <= 1'b1;
      wr_en_y_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      done_q      <= done_d;
      clear_acc_q <= clear_acc_d;
      wr_en_y_q   <= wr_en_y_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.done      = done_q;
  assign bus.clear_acc = clear_acc_q;
  assign bus.wr_en_y   = wr_en_y_q;
  assign bus.wr_en_a   = (state_q == LOAD_A) && bus.s_valid;
  assign bus.wr_en_x   = (state_q == LOAD_X) && bus.s_valid;
  assign bus.addr_a    = addr_a;
  assign bus.addr_x    = addr_x;
  assign bus.addr_y    = addr_y;

endmodule

// File: tb/tb_mvm_stream_ctrl.sv
// Bench: behavioural datapath around the controller, y = A*x reference, per-cycle compare.
module tb_mvm_stream_ctrl;
  import mvm_pkg::*;

  localparam int N  = MAT_SCALE;
  localparam int NN = MAT_SCALE * MAT_SCALE;

  logic  clk = 1'b0;
  logic  reset;
  logic  s_valid;
  logic  m_ready;
  elem_t s_data;

  always #5 clk = ~clk;

  mvm_stream_ctrl_if bus ();
  assign bus.s_valid = s_valid;
  assign bus.m_ready = m_ready;

  mvm_stream_ctrl #(.MAT_SCALE(MAT_SCALE)) dut (.clk(clk), .reset(reset), .bus(bus));

  // datapath harness: synchronous-read memories and the MAC register
  elem_t mem_a [1 << MAT_ADDR_W];
  elem_t mem_x [1 << VEC_ADDR_W];
  acc_t  mem_y [1 << VEC_ADDR_W];
  elem_t a_rd, x_rd;
  acc_t  acc, data_out, add_out;

  assign add_out = acc_t'(int'(a_rd) * int'(x_rd) + int'(acc));

  always @(posedge clk) begin
    if (bus.wr_en_a) mem_a[bus.addr_a] <= s_data;
    if (bus.wr_en_x) mem_x[bus.addr_x] <= s_data;
    if (bus.wr_en_y) mem_y[bus.addr_y] <= add_out;
    a_rd     <= mem_a[bus.addr_a];
    x_rd     <= mem_x[bus.addr_x];
    data_out <= mem_y[bus.addr_y];
    acc      <= bus.clear_acc ? '0 : add_out;
  end

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     last_x_cyc = 0;
  int     out_idx = 0, ld_a = 0, ld_x = 0, done_cnt = 0;
  elem_t  a_m [NN];
  elem_t  x_v [N];
  acc_t   y_exp [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void compute_model();
    for (int i = 0; i < N; i++) begin
      int sum = 0;
      for (int j = 0; j < N; j++) sum += int'(a_m[i*N + j]) * int'(x_v[j]);
      y_exp[i] = acc_t'(sum);
    end
  endfunction

  // per-cycle compare of load writes, y stream and done against the model
  always @(negedge clk) begin
    if (!reset) begin
      out_idx = 0;
      ld_a    = 0;
      ld_x    = 0;
    end else begin
      if (bus.wr_en_a) begin
        chk("wr_a_needs_valid", bus.s_valid, 1);
        chk("addr_a_seq", bus.addr_a, ld_a);
        ld_a = (ld_a + 1) % NN;
      end
      if (bus.wr_en_x) begin
        chk("wr_x_needs_valid", bus.s_valid, 1);
        chk("addr_x_seq", bus.addr_x, ld_x);
        ld_x = (ld_x + 1) % N;
      end
      if (bus.s_valid && bus.s_ready) chk("load_write", bus.wr_en_a ^ bus.wr_en_x, 1);
      if (bus.m_valid) begin
        if (out_idx < N) begin
          chk("addr_y", bus.addr_y, out_idx);
          chk("y_data", data_out, y_exp[out_idx]);
        end else begin
          chk("y_overrun", out_idx, N - 1);
        end
        if (bus.m_ready) out_idx++;
      end
      if (bus.done) begin
        chk("done_after_all_y", out_idx, N);
        out_idx = 0;
        done_cnt++;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"},   bus.s_ready, 0);
    chk({tag, "_m_valid"},   bus.m_valid, 0);
    chk({tag, "_wr_en_a"},   bus.wr_en_a, 0);
    chk({tag, "_wr_en_x"},   bus.wr_en_x, 0);
    chk({tag, "_wr_en_y"},   bus.wr_en_y, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_clear_acc"}, bus.clear_acc, 1);
    chk({tag, "_addr_a"},    bus.addr_a, 0);
    chk({tag, "_addr_x"},    bus.addr_x, 0);
    chk({tag, "_addr_y"},    bus.addr_y, 0);
  endtask

  // feeds A then x; starts and ends at posedge+1
  task automatic load_job(input int gap_pct);
    int  k = 0;
    int  waitc = 0;
    bit  hs;
    while (k < NN + N) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = (k < NN) ? a_m[k] : x_v[k - NN];
      @(negedge clk);
      hs = s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (hs) k++;
      waitc++;
      if (waitc > 2000) begin
        chk("load_timeout", k, NN + N);
        break;
      end
    end
    s_valid    = 1'b0;
    last_x_cyc = cyc;
  endtask

  task automatic drain_job(input int stall_idx, input int stall_len, input int bp_pct);
    int stall_ctr = 0;
    int waitc = 0;
    int d0 = done_cnt;
    bit seen = 0, fin = 0, hold = 0;
    while (!fin) begin
      if (hold) chk("m_valid_hold", bus.m_valid, 1);
      if (bus.m_valid && out_idx == stall_idx && stall_ctr < stall_len) begin
        m_ready = 1'b0;
        stall_ctr++;
      end else begin
        m_ready = ($urandom_range(99) >= bp_pct);
      end
      hold = bus.m_valid && !m_ready;
      @(negedge clk);
      if (bus.m_valid && !seen) begin
        seen = 1;
        chk("first_m_valid_latency", cyc - last_x_cyc, NN + 2);
      end
      if (bus.done) fin = 1;
      waitc++;
      if (waitc > 500) begin
        chk("drain_timeout", 0, 1);
        fin = 1;
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("done_single_cycle", bus.done, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("s_ready_after_done", bus.s_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    reset   = 1'b1;
    #3 reset = 1'b0;
    #1 chk_reset("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // counting matrix, x = 1,2,3, no backpressure
    for (int k = 0; k < NN; k++) a_m[k] = elem_t'(k + 1);
    for (int j = 0; j < N; j++)  x_v[j] = elem_t'(j + 1);
    compute_model();
    chk("model_y0", y_exp[0], 14);
    chk("model_y1", y_exp[1], 32);
    chk("model_y2", y_exp[2], 50);
    load_job(0);
    drain_job(-1, 0, 0);

    // most-negative operands: sum wraps to -16384
    for (int k = 0; k < NN; k++) a_m[k] = elem_t'(-128);
    for (int j = 0; j < N; j++)  x_v[j] = elem_t'(-128);
    compute_model();
    chk("model_wrap", y_exp[0], -16384);
    load_job(0);
    drain_job(-1, 0, 0);

    // counting data again with load gaps and a 5-cycle stall on y[1]
    for (int k = 0; k < NN; k++) a_m[k] = elem_t'(k + 1);
    for (int j = 0; j < N; j++)  x_v[j] = elem_t'(j + 1);
    compute_model();
    load_job(50);
    drain_job(1, 5, 0);

    // random operands, gaps and backpressure
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NN; k++) a_m[k] = elem_t'($urandom);
      for (int j = 0; j < N; j++)  x_v[j] = elem_t'($urandom);
      compute_model();
      load_job(50);
      drain_job(-1, 0, 40);
    end

    // abort in the middle of COMPUTE
    load_job(0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset("mid");
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", bus.done, 0);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    // identity matrix passes x straight through
    for (int k = 0; k < NN; k++) a_m[k] = elem_t'((k % (N + 1) == 0) ? 1 : 0);
    x_v[0] = elem_t'(7);
    x_v[1] = elem_t'(-3);
    x_v[2] = elem_t'(5);
    compute_model();
    chk("model_ident_y1", y_exp[1], -3);
    load_job(0);
    drain_job(-1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mvm_stream_ctrl.md
Name: mvm_stream_ctrl

Overview:
- Streaming controller that sequences the matrix-vector multiply datapath (mem_a, mem_x, mem_y, multiply-accumulate register).
- Loads A (row-major) and x from a valid/ready input stream.
- Runs a fully pipelined MAC schedule at one product per cycle.
- Drains y over a valid/ready output stream with backpressure, then pulses done.
- Replaces the start-driven control FSM for stream-attached use.

Parameters:
MAT_SCALE, 3, matrix dimension N (N >= 2)
INPUT_WIDTH, 8, signed element width of A and x
OUTPUT_WIDTH, 16, signed width of y
VEC_ADDR_W, $clog2(MAT_SCALE), address width of mem_x and mem_y
MAT_ADDR_W, $clog2(MAT_SCALE*MAT_SCALE), address width of mem_a

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
s_valid  in  1  input element valid
s_ready  out  1  controller accepts an element
m_valid  out  1  data_out (datapath mem_y read port) holds a valid y element
m_ready  in  1  downstream accepts the y element
wr_en_a  out  1  mem_a write enable
addr_a  out  MAT_ADDR_W  mem_a address
wr_en_x  out  1  mem_x write enable
addr_x  out  VEC_ADDR_W  mem_x address
wr_en_y  out  1  mem_y write enable
addr_y  out  VEC_ADDR_W  mem_y address
clear_acc  out  1  accumulator clear
done  out  1  one-cycle pulse after the last y element is accepted

Behaviour:
- Datapath contract:
  - Memories are synchronous-read: data appears 1 cycle after the address.
  - The datapath computes add_out = a*x + acc.
  - acc <= clear_acc ? 0 : add_out.
  - mem_y writes add_out when wr_en_y is high.
  - Products are full-width signed; the sum wraps modulo 2^OUTPUT_WIDTH with no saturation.
- Reset (reset == 0, async):
  - State goes to IDLE and all counters go to 0.
  - s_ready=0, m_valid=0, all wr_en=0, done=0, clear_acc=1, all addr=0.
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN, OUT_ADDR, OUT_VALID.
- IDLE: always moves to LOAD_A on the next cycle. done=1 only when IDLE is entered from OUT_VALID.
- LOAD_A:
  - s_ready=1; wr_en_a = s_valid (combinational).
  - addr_a increments on each handshake.
  - After the N*N-th handshake (addr_a==N*N-1): addr_a goes to 0 and the state moves to LOAD_X.
  - Gaps in s_valid stall the load with no state change.
- LOAD_X: same scheme using wr_en_x and addr_x. After the N-th handshake, go to COMPUTE with addr_a=0 and addr_x=0.
- COMPUTE (N*N cycles, s_ready=0):
  - Each cycle issues (addr_a, addr_x); addr_a increments.
  - addr_x wraps N-1 to 0.
  - A one-cycle delayed tag records product_valid, row index and last_in_row.
- MAC timing:
  - A product is on add_out one cycle after its issue.
  - clear_acc = !product_valid || last_in_row.
  - wr_en_y = product_valid && last_in_row, with addr_y = delayed row index.
  - Row i is written at issue-cycle (i+1)*N; the last row is written in DRAIN.
- DRAIN: 1 cycle, finishes the final write. Then set addr_y=0 and go to OUT_ADDR.
- OUT_ADDR: m_valid=0, mem_y reads addr_y. Go to OUT_VALID.
- OUT_VALID:
  - m_valid=1, and addr_y is held until m_ready.
  - data_out stays stable under backpressure.
  - On handshake with addr_y==N-1: go to IDLE (done pulse).
  - On handshake otherwise: addr_y++ and go to OUT_ADDR.
  - Sustained throughput is one y element per 2 cycles.
- Latency: m_valid first rises N*N+2 cycles after the edge that accepts the last x element (11 for N=3).
- s_valid during COMPUTE/DRAIN/OUT_* is ignored (s_ready=0). m_ready outside OUT_VALID is ignored.
- Reset asserted mid-operation:
  - Immediate async return to IDLE; the partial result is discarded and no done pulse is issued.
  - Memory contents are undefined for the next job until reloaded.

Decomposition:
- Package mvm_pkg:
  - state_t enum (IDLE..OUT_VALID).
  - Width localparams derived from MAT_SCALE.
  - Signed element typedefs elem_t and acc_t.
- Sub-module wrap_counter #(WIDTH, TOP):
  - Ports: clk, reset (async active-low), en, clr, out, last.
  - last = (out==TOP); wraps to 0 on en when last.
  - Instantiated for addr_a, addr_x and addr_y.

Test Plan:
- N=3, A=1..9 row-major, x=1,2,3, m_ready=1 -> y=14,32,50 in order; done pulses once; m_valid first rises exactly 11 cycles after the last-x edge.
- A=-128 all, x=-128 all -> each y=49152 mod 2^16 = -16384.
- Random s_valid gaps (50%) during the load, same data -> identical y; no write when s_valid=0; addr_a/addr_x never skip.
- m_ready held low 5 cycles on y[1] -> m_valid stays 1, data_out=32 stable, addr_y=1 unchanged; resumes correctly.
- reset pulled low at COMPUTE cycle 4 -> all outputs at reset values asynchronously, no done; a subsequent full job with A=I, x=7,-3,5 -> y=7,-3,5.
- Back-to-back jobs with m_ready=1 -> second load starts 1 cycle after done (s_ready=1 in LOAD_A); second y is correct, with no accumulator carry-over.
